// File: rtl/fetch.sv
// Instruction fetch stage: drives the I-cache handshake, holds the fetch PC and
// a one-entry skid buffer, and redirects on jmp without abandoning a live request.
//
// state | meaning
// FETCH | buffer empty, requesting fpc every cycle
// FULL  | buffer holds one insn; request only while issue is not stalled
// DRAIN | finishing a request left open by jmp; its data is discarded
module fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        Nrst,
    input  logic        stall,
    input  logic        jmp,
    input  logic [31:0] jmppc,
    output logic        ic_rd_req,
    output logic [31:0] ic_addr,
    input  logic [31:0] ic_rd_data,
    input  logic        ic_ready,
    output logic        bubble,
    output logic [31:0] insn,
    output logic [31:0] pc
);

    typedef enum logic [1:0] {FETCH, FULL, DRAIN} state_t;

    state_t      state, state_nxt;
    logic [31:0] fpc, fpc_nxt;
    logic [31:0] buf_insn, buf_insn_nxt;
    logic [31:0] buf_pc, buf_pc_nxt;
    logic [31:0] drain_addr, drain_addr_nxt;
    logic        bubble_nxt;
    logic [31:0] insn_nxt, pc_nxt;
    logic        xfer;

    always_ff @(posedge clk) begin
        if (!Nrst) begin
            state      <= FETCH;
            fpc        <= RESET_PC;
            buf_insn   <= 32'h0;
            buf_pc     <= 32'h0;
            drain_addr <= 32'h0;
            bubble     <= 1'b1;
            insn       <= 32'h0;
            pc         <= 32'h0;
        end else begin
            state      <= state_nxt;
            fpc        <= fpc_nxt;
            buf_insn   <= buf_insn_nxt;
            buf_pc     <= buf_pc_nxt;
            drain_addr <= drain_addr_nxt;
            bubble     <= bubble_nxt;
            insn       <= insn_nxt;
            pc         <= pc_nxt;
        end
    end

    // Request side: in DRAIN the abandoned address is held until the cache accepts it.
    always_comb begin
        ic_rd_req = 1'b0;
        ic_addr   = fpc;
        case (state)
            FETCH: ic_rd_req = 1'b1;
            FULL:  ic_rd_req = !stall;
            DRAIN: begin
                ic_rd_req = 1'b1;
                ic_addr   = drain_addr;
            end
            default: ic_rd_req = 1'b0;
        endcase
        if (!Nrst)
            ic_rd_req = 1'b0;
    end

    assign xfer = ic_rd_req && ic_ready;

    always_comb begin
        state_nxt      = state;
        fpc_nxt        = fpc;
        buf_insn_nxt   = buf_insn;
        buf_pc_nxt     = buf_pc;
        drain_addr_nxt = drain_addr;
        bubble_nxt     = bubble;
        insn_nxt       = insn;
        pc_nxt         = pc;

        if (jmp) begin
            // Redirect wins over stall; any data landing this cycle is dropped.
            bubble_nxt     = 1'b1;
            fpc_nxt        = jmppc & 32'hFFFF_FFFC;
            drain_addr_nxt = ic_addr;
            state_nxt      = (ic_rd_req && !ic_ready) ? DRAIN : FETCH;
        end else begin
            case (state)
                FETCH: begin
                    if (xfer)
                        fpc_nxt = fpc + 32'd4;
                    if (stall) begin
                        if (xfer) begin
                            buf_insn_nxt = ic_rd_data;
                            buf_pc_nxt   = fpc;
                            state_nxt    = FULL;
                        end
                    end else if (xfer) begin
                        bubble_nxt = 1'b0;
                        insn_nxt   = ic_rd_data;
                        pc_nxt     = fpc;
                    end else begin
                        bubble_nxt = 1'b1;
                    end
                end
                FULL: begin
                    if (!stall) begin
                        bubble_nxt = 1'b0;
                        insn_nxt   = buf_insn;
                        pc_nxt     = buf_pc;
                        if (xfer) begin
                            buf_insn_nxt = ic_rd_data;
                            buf_pc_nxt   = fpc;
                            fpc_nxt      = fpc + 32'd4;
                        end else begin
                            state_nxt = FETCH;
                        end
                    end
                end
                DRAIN: begin
                    bubble_nxt = 1'b1;
                    if (ic_ready)
                        state_nxt = FETCH;
                end
                default: state_nxt = FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch.sv
// Bench for fetch: directed test-plan sequence plus a random phase, with a
// scoreboard of expected (pc, insn) pairs pushed on accepted transfers.
module tb_fetch;

    localparam logic [31:0] RST_PC = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        Nrst, stall, jmp, rdy;
    logic [31:0] jmppc;
    logic        ic_rd_req, ic_ready, bubble;
    logic [31:0] ic_addr, ic_rd_data, insn, pc;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] insn;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A5A, ~a[31:16]};
    endfunction

    assign ic_ready   = rdy;
    assign ic_rd_data = mem_word(ic_addr);

    fetch #(.RESET_PC(RST_PC)) dut (
        .clk       (clk),
        .Nrst      (Nrst),
        .stall     (stall),
        .jmp       (jmp),
        .jmppc     (jmppc),
        .ic_rd_req (ic_rd_req),
        .ic_addr   (ic_addr),
        .ic_rd_data(ic_rd_data),
        .ic_ready  (ic_ready),
        .bubble    (bubble),
        .insn      (insn),
        .pc        (pc)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: expected fetch address and instruction stream kept by the bench.
    logic        was_rst = 1'b1;
    logic        prev_stall = 1'b0, prev_jmp = 1'b0, prev_req = 1'b0, prev_rdy = 1'b0;
    logic [31:0] prev_addr = 32'h0;
    logic        last_bubble = 1'b1;
    logic [31:0] last_pc = 32'h0, last_insn = 32'h0;
    logic        draining = 1'b0;
    logic [31:0] exp_addr = RST_PC;

    always @(negedge clk) begin
        if (!Nrst) begin
            sb.delete();
            draining = 1'b0;
            exp_addr = RST_PC;
            was_rst  = 1'b1;
        end else begin
            if (was_rst || prev_jmp) begin
                chk("sb_bubble_after_flush", {31'h0, bubble}, 32'h1);
            end else if (prev_stall) begin
                chk("sb_hold_bubble", {31'h0, bubble}, {31'h0, last_bubble});
                chk("sb_hold_pc", pc, last_pc);
                chk("sb_hold_insn", insn, last_insn);
            end else if (sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_bubble", {31'h0, bubble}, 32'h0);
                chk("sb_pc", pc, e.pc);
                chk("sb_insn", insn, e.insn);
            end else begin
                chk("sb_idle_bubble", {31'h0, bubble}, 32'h1);
            end
            chk("sb_one_buffered", {31'h0, sb.size() <= 1}, 32'h1);
            if (!was_rst && prev_req && !prev_rdy) begin
                chk("hs_req_held", {31'h0, ic_rd_req}, 32'h1);
                chk("hs_addr_held", ic_addr, prev_addr);
            end
            if (ic_rd_req && !draining)
                chk("sb_fetch_addr", ic_addr, exp_addr);
            if (jmp) begin
                sb.delete();
                draining = ic_rd_req && !ic_ready;
                exp_addr = jmppc & 32'hFFFF_FFFC;
            end else if (ic_rd_req && ic_ready) begin
                if (draining) begin
                    draining = 1'b0;
                end else begin
                    sb.push_back('{pc: exp_addr, insn: mem_word(exp_addr)});
                    exp_addr = exp_addr + 32'd4;
                end
            end
            was_rst = 1'b0;
        end
        prev_stall  = stall;
        prev_jmp    = jmp;
        prev_req    = ic_rd_req;
        prev_rdy    = ic_ready;
        prev_addr   = ic_addr;
        last_bubble = bubble;
        last_pc     = pc;
        last_insn   = insn;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        Nrst = 1'b0; stall = 1'b0; jmp = 1'b0; jmppc = 32'h0; rdy = 1'b1;
        tick(); tick();
        @(negedge clk);
        chk("rst_bubble", {31'h0, bubble}, 32'h1);
        chk("rst_insn", insn, 32'h0);
        chk("rst_pc", pc, 32'h0);
        chk("rst_req", {31'h0, ic_rd_req}, 32'h0);

        tick(); Nrst = 1'b1;
        @(negedge clk);
        chk("first_req", {31'h0, ic_rd_req}, 32'h1);
        chk("first_addr", ic_addr, 32'h100);
        chk("first_bubble", {31'h0, bubble}, 32'h1);
        tick(); @(negedge clk);
        chk("pc_100", pc, 32'h100);
        chk("insn_100", insn, mem_word(32'h100));

        // three stalled cycles starting while pc=0x104 is presented
        tick(); stall = 1'b1; @(negedge clk);
        chk("stall_pc0", pc, 32'h104);
        for (int i = 0; i < 2; i++) begin
            tick(); @(negedge clk);
            chk("stall_pc", pc, 32'h104);
            chk("stall_req", {31'h0, ic_rd_req}, 32'h0);
        end
        tick(); stall = 1'b0; @(negedge clk);
        chk("release_req", {31'h0, ic_rd_req}, 32'h1);
        chk("release_addr", ic_addr, 32'h10C);
        tick(); @(negedge clk);
        chk("release_pc108", pc, 32'h108);
        tick(); @(negedge clk);
        chk("release_pc10c", pc, 32'h10C);

        tick(); jmp = 1'b1; jmppc = 32'h2000; @(negedge clk);
        chk("pre_jmp_pc", pc, 32'h110);
        tick(); jmp = 1'b0; @(negedge clk);
        chk("jmp_bubble", {31'h0, bubble}, 32'h1);
        chk("jmp_addr", ic_addr, 32'h2000);
        tick(); @(negedge clk);
        chk("jmp_pc", pc, 32'h2000);
        chk("jmp_bubble_off", {31'h0, bubble}, 32'h0);

        // jmp and stall together, unaligned target
        tick(); jmp = 1'b1; stall = 1'b1; jmppc = 32'h5003; @(negedge clk);
        tick(); jmp = 1'b0; stall = 1'b0; @(negedge clk);
        chk("jmpstall_bubble", {31'h0, bubble}, 32'h1);
        chk("jmpstall_addr", ic_addr, 32'h5000);
        tick(); @(negedge clk);
        chk("jmpstall_pc", pc, 32'h5000);

        tick(); jmp = 1'b1; jmppc = 32'hFFFF_FFF8; @(negedge clk);
        tick(); jmp = 1'b0; @(negedge clk);
        tick(); @(negedge clk);
        chk("wrap_pc_fff8", pc, 32'hFFFF_FFF8);
        tick(); @(negedge clk);
        chk("wrap_pc_fffc", pc, 32'hFFFF_FFFC);
        chk("wrap_addr", ic_addr, 32'h0);
        tick(); rdy = 1'b0; jmp = 1'b1; jmppc = 32'h40; @(negedge clk);
        chk("wrap_pc_0", pc, 32'h0);

        // drain of address 4, then a redirect to 0x3000 while 0x40 is stuck
        tick(); jmp = 1'b0; rdy = 1'b1; @(negedge clk);
        chk("drain1_addr", ic_addr, 32'h4);
        tick(); rdy = 1'b0; jmp = 1'b1; jmppc = 32'h3000; @(negedge clk);
        chk("drain2_first_addr", ic_addr, 32'h40);
        for (int i = 0; i < 3; i++) begin
            tick(); jmp = 1'b0; @(negedge clk);
            chk("drain2_addr", ic_addr, 32'h40);
            chk("drain2_req", {31'h0, ic_rd_req}, 32'h1);
            chk("drain2_bubble", {31'h0, bubble}, 32'h1);
        end
        tick(); rdy = 1'b1; @(negedge clk);
        chk("drain2_done_addr", ic_addr, 32'h40);
        tick(); @(negedge clk);
        chk("drain2_target", ic_addr, 32'h3000);
        chk("drain2_bubble_end", {31'h0, bubble}, 32'h1);

        // reset while stalled with the buffer full
        tick(); stall = 1'b1; @(negedge clk);
        chk("redir_pc", pc, 32'h3000);
        tick(); @(negedge clk);
        chk("full_req", {31'h0, ic_rd_req}, 32'h0);
        tick(); Nrst = 1'b0; @(negedge clk);
        tick(); Nrst = 1'b1; stall = 1'b0; @(negedge clk);
        chk("rst2_bubble", {31'h0, bubble}, 32'h1);
        chk("rst2_pc", pc, 32'h0);
        chk("rst2_addr", ic_addr, 32'h100);
        tick(); @(negedge clk);
        chk("rst2_pc100", pc, 32'h100);

        for (int i = 0; i < 500; i++) begin
            tick();
            stall = ($urandom_range(0, 99) < 30);
            rdy   = ($urandom_range(0, 99) < 70);
            jmp   = ($urandom_range(0, 99) < 6);
            jmppc = $urandom;
        end
        tick(); stall = 1'b0; jmp = 1'b0; rdy = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
